// File: rtl/ramb16_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ramb16_fifo_pkg                                                        |
// | Shared widths and types for the nibble-to-word RAMB16 FIFO controller. |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package ramb16_fifo_pkg;

    localparam int NIB_PTR_W     = 13;
    localparam int WORD_PTR_W    = 11;
    localparam int RAM_A_AW      = 12;
    localparam int RAM_B_AW      = 10;
    localparam int NIBS_PER_WORD = 4;
    localparam int CAPACITY_NIB  = 4096;

    typedef logic [NIB_PTR_W-1:0]  nib_ptr_t;
    typedef logic [WORD_PTR_W-1:0] word_ptr_t;
    typedef logic [3:0]            nibble_t;
    typedef logic [15:0]           word_t;

endpackage
`default_nettype wire

// File: rtl/ramb16_s4_s18_fifo_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ramb16_s4_s18_fifo_ctrl_if                                             |
// | Nibble push stream and word pop stream of the width-converting FIFO.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
interface ramb16_s4_s18_fifo_ctrl_if;
    import ramb16_fifo_pkg::*;

    logic    nib_valid;
    nibble_t nib_data;
    logic    nib_ready;
    logic    word_valid;
    word_t   word_data;
    logic    word_ready;

    // master: the surrounding system (producer of nibbles, consumer of words)
    modport master (
        output nib_valid, nib_data, word_ready,
        input  nib_ready, word_valid, word_data
    );

    modport slave (
        input  nib_valid, nib_data, word_ready,
        output nib_ready, word_valid, word_data
    );

endinterface
`default_nettype wire

// File: rtl/ramb16_fifo_obuf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ramb16_fifo_obuf                                                       |
// | Two-entry 16-bit output buffer with capture, pop and clear.            |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module ramb16_fifo_obuf
    import ramb16_fifo_pkg::*;
(
    input  wire logic  clk,
    input  wire logic  rst,
    input  wire logic  i_capture,
    input  wire word_t i_data,
    input  wire logic  i_pop,
    output word_t      o_head,
    output logic [1:0] o_count
);

    word_t      r_mem [2];
    logic       r_wsel;
    logic       r_rsel;
    logic [1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wsel   <= 1'b0;
            r_rsel   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_capture) begin
                r_mem[r_wsel] <= i_data;
                r_wsel        <= ~r_wsel;
            end
            if (i_pop) begin
                r_rsel <= ~r_rsel;
            end
            case ({i_capture, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rsel];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ramb16_s4_s18_fifo_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | ramb16_s4_s18_fifo_ctrl                                                |
// | Nibble-in / word-out FIFO controller around one RAMB16_S4_S18.         |
// | Optional RAMB_FIFO_LEVEL_EN adds fill_words / almost_full outputs.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module ramb16_s4_s18_fifo_ctrl
    import ramb16_fifo_pkg::*;
#(
    parameter int AFULL_WORDS = 1000,
    parameter int OBUF_DEPTH  = 2
)(
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic                  flush,
    ramb16_s4_s18_fifo_ctrl_if.slave   bus,
    output logic [RAM_A_AW-1:0]        ram_addra,
    output nibble_t                    ram_dia,
    output logic                       ram_ena,
    output logic                       ram_wea,
    output logic [RAM_B_AW-1:0]        ram_addrb,
    output logic                       ram_enb,
    input  wire word_t                 ram_dob
`ifdef RAMB_FIFO_LEVEL_EN
    ,
    output logic [11:0]                fill_words,
    output logic                       almost_full
`endif
);

    nib_ptr_t   r_wr_ptr;
    word_ptr_t  r_rd_ptr;
    logic       r_inflight;

    logic       w_hold;
    nib_ptr_t   w_used_nib;
    logic       w_full;
    word_ptr_t  w_avail;
    logic       w_push;
    logic       w_pop;
    logic       w_issue;
    logic [1:0] w_obuf_count;
    word_t      w_head;

    assign w_hold     = reset | flush;
    assign w_used_nib = r_wr_ptr - {r_rd_ptr, 2'b00};
    assign w_full     = (w_used_nib == nib_ptr_t'(CAPACITY_NIB));
    // Only complete words count; a partially written word is never issued.
    assign w_avail    = r_wr_ptr[NIB_PTR_W-1:$clog2(NIBS_PER_WORD)] - r_rd_ptr;

    assign bus.nib_ready = !w_full && !w_hold;
    assign w_push        = bus.nib_valid && bus.nib_ready;
    assign w_issue       = !w_hold && (w_avail != '0)
                        && ((int'(w_obuf_count) + int'(r_inflight)) < OBUF_DEPTH);

    assign ram_ena   = w_push;
    assign ram_wea   = w_push;
    assign ram_dia   = w_push ? bus.nib_data : '0;
    assign ram_addra = w_hold ? '0 : r_wr_ptr[RAM_A_AW-1:0];
    assign ram_enb   = w_issue;
    assign ram_addrb = w_hold ? '0 : r_rd_ptr[RAM_B_AW-1:0];

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + nib_ptr_t'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + word_ptr_t'(1);
            end
            r_inflight <= w_issue;
        end
    end

    assign w_pop = bus.word_valid && bus.word_ready;

    ramb16_fifo_obuf u_obuf (
        .clk       (clk),
        .rst       (w_hold),
        .i_capture (r_inflight),
        .i_data    (ram_dob),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_obuf_count)
    );

    assign bus.word_valid = (w_obuf_count != 2'd0) && !w_hold;
    assign bus.word_data  = w_hold ? '0 : w_head;

`ifdef RAMB_FIFO_LEVEL_EN
    logic [11:0] w_fill;
    logic [11:0] r_fill;
    logic        r_afull;

    // Threshold counts every complete word held, including the output buffer.
    assign w_fill = 12'(w_avail) + 12'(w_obuf_count) + 12'(r_inflight);

    always_ff @(posedge clk) begin
        if (w_hold) begin
            r_fill  <= '0;
            r_afull <= 1'b0;
        end else begin
            r_fill  <= w_fill;
            r_afull <= (int'(w_fill) >= AFULL_WORDS);
        end
    end

    assign fill_words  = r_fill;
    assign almost_full = r_afull;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ramb16_s4_s18_fifo_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_ramb16_s4_s18_fifo_ctrl                                             |
// | Directed bench for the nibble-to-word FIFO with a RAMB16 model.        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_ramb16_s4_s18_fifo_ctrl;

`ifdef RAMB_FIFO_LEVEL_EN
    localparam int TB_AFULL = 4;
`else
    localparam int TB_AFULL = 1000;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic [11:0] ram_addra;
    logic [3:0]  ram_dia;
    logic        ram_ena;
    logic        ram_wea;
    logic [9:0]  ram_addrb;
    logic        ram_enb;
    logic [15:0] ram_dob;
`ifdef RAMB_FIFO_LEVEL_EN
    logic [11:0] fill_words;
    logic        almost_full;
`endif

    ramb16_s4_s18_fifo_ctrl_if bus ();

    ramb16_s4_s18_fifo_ctrl #(
        .AFULL_WORDS (TB_AFULL),
        .OBUF_DEPTH  (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .bus         (bus),
        .ram_addra   (ram_addra),
        .ram_dia     (ram_dia),
        .ram_ena     (ram_ena),
        .ram_wea     (ram_wea),
        .ram_addrb   (ram_addrb),
        .ram_enb     (ram_enb),
        .ram_dob     (ram_dob)
`ifdef RAMB_FIFO_LEVEL_EN
        ,
        .fill_words  (fill_words),
        .almost_full (almost_full)
`endif
    );

    // Behavioural 4Kx4 / 1Kx16 block RAM, port B read-only
    logic [3:0] ram_mem [4096];
    always @(posedge clk) begin
        if (ram_ena && ram_wea) ram_mem[ram_addra] <= ram_dia;
        if (ram_enb) ram_dob <= {ram_mem[{ram_addrb, 2'd3}], ram_mem[{ram_addrb, 2'd2}],
                                 ram_mem[{ram_addrb, 2'd1}], ram_mem[{ram_addrb, 2'd0}]};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass;
    int          n_total;
    int          acc_cnt;
    logic        s_ready, s_wv, s_ena, s_wea, s_enb, s_acc;
    logic [15:0] s_wd;
    logic [3:0]  s_dia;
    logic [11:0] s_addra;
    logic [9:0]  s_addrb;
    logic [15:0] m_word;
    int          m_cnt;
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic cycle(input logic v, input logic [3:0] d, input logic wr);
        bus.nib_valid  = v;
        bus.nib_data   = d;
        bus.word_ready = wr;
        #1;
        s_ready = bus.nib_ready;
        s_wv    = bus.word_valid;
        s_wd    = bus.word_data;
        s_ena   = ram_ena;
        s_wea   = ram_wea;
        s_dia   = ram_dia;
        s_addra = ram_addra;
        s_enb   = ram_enb;
        s_addrb = ram_addrb;
        s_acc   = v && s_ready;
        if (reset || flush) begin
            exp_q.delete();
            m_word = '0;
            m_cnt  = 0;
        end
        if (s_acc) begin
            acc_cnt++;
            m_word[4*m_cnt +: 4] = d;
            m_cnt++;
            if (m_cnt == 4) begin
                exp_q.push_back(m_word);
                m_word = '0;
                m_cnt  = 0;
            end
        end
        if (s_wv && wr) got_q.push_back(s_wd);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        reset = 1'b0;
        got_q.delete();
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle(1'b1, 4'hF, 1'b1);
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL reset_nib_ready: got %b want 0", s_ready);
        else n_pass++;
        n_total++;
        if (s_wv !== 1'b0 || s_wd !== 16'h0)
            $display("FAIL reset_word: valid=%b data=%h want 0/0000", s_wv, s_wd);
        else n_pass++;
        n_total++;
        if ({s_ena, s_wea, s_enb, s_dia, s_addra, s_addrb} !== '0)
            $display("FAIL reset_ram: ena=%b wea=%b enb=%b dia=%h addra=%h addrb=%h want all 0",
                     s_ena, s_wea, s_enb, s_dia, s_addra, s_addrb);
        else n_pass++;
        reset = 1'b0;
        got_q.delete();
        acc_cnt = 0;
        cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (s_ready !== 1'b1 || s_wv !== 1'b0)
            $display("FAIL post_reset: ready=%b valid=%b want 1/0", s_ready, s_wv);
        else n_pass++;
    endtask

    task automatic test_single_word();
        int first_v;
        do_reset();
        cycle(1'b1, 4'h1, 1'b1);
        n_total++;
        if ({s_ena, s_wea, s_dia, s_addra} !== {1'b1, 1'b1, 4'h1, 12'h000})
            $display("FAIL write_port: ena=%b wea=%b dia=%h addra=%h want 1/1/1/000",
                     s_ena, s_wea, s_dia, s_addra);
        else n_pass++;
        cycle(1'b1, 4'h2, 1'b1);
        cycle(1'b1, 4'h3, 1'b1);
        cycle(1'b1, 4'h4, 1'b1);
        first_v = -1;
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 4'h0, 1'b1);
            if (k == 1) begin
                n_total++;
                if (s_enb !== 1'b1 || s_addrb !== 10'd0)
                    $display("FAIL read_issue: enb=%b addrb=%h want 1/000", s_enb, s_addrb);
                else n_pass++;
            end
            if (s_wv && first_v < 0) first_v = k;
        end
        n_total++;
        if (first_v !== 3) $display("FAIL latency: word_valid after %0d cycles want 3", first_v);
        else n_pass++;
        n_total++;
        if (got_q.size() !== 1 || got_q[0] !== 16'h4321)
            $display("FAIL single_word: count=%0d first=%h want 1/4321", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        else n_pass++;
    endtask

    task automatic test_partial();
        int seen;
        do_reset();
        cycle(1'b1, 4'h1, 1'b1);
        cycle(1'b1, 4'h2, 1'b1);
        cycle(1'b1, 4'h3, 1'b1);
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            cycle(1'b0, 4'h0, 1'b1);
            if (s_wv) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL partial_hidden: word_valid high %0d cycles want 0", seen);
        else n_pass++;
        cycle(1'b1, 4'hA, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (got_q.size() !== 1 || got_q[0] !== 16'hA321)
            $display("FAIL partial_complete: count=%0d first=%h want 1/A321", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        else n_pass++;
    endtask

    task automatic test_full();
        int bad;
        do_reset();
        // 1024 RAM words plus the two words already moved into the output buffer
        for (int i = 0; i < 4110; i++) cycle(1'b1, 4'(i * 7 + 3), 1'b0);
        n_total++;
        if (acc_cnt !== 4104 || s_ready !== 1'b0)
            $display("FAIL full_accepts: accepted=%0d ready=%b want 4104/0", acc_cnt, s_ready);
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (s_wv !== 1'b1) $display("FAIL full_pop: word_valid=%b want 1", s_wv);
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b0);
        n_total++;
        if (s_ready !== 1'b0) $display("FAIL full_ready_p1: ready=%b want 0", s_ready);
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b0);
        n_total++;
        if (s_ready !== 1'b1) $display("FAIL full_ready_p2: ready=%b want 1", s_ready);
        else n_pass++;
        for (int k = 0; k < 4000 && got_q.size() < 1026; k++) cycle(1'b0, 4'h0, 1'b1);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        n_total++;
        if (got_q.size() !== 1026 || exp_q.size() !== 1026 || bad != 0)
            $display("FAIL full_order: got=%0d model=%0d mismatched=%0d want 1026/1026/0",
                     got_q.size(), exp_q.size(), bad);
        else n_pass++;
    endtask

    task automatic test_stream();
        int bad;
        do_reset();
        for (int k = 0; k < 60000 && acc_cnt < 10000; k++)
            cycle(1'($urandom % 2), 4'($urandom), 1'($urandom % 2));
        for (int k = 0; k < 4000 && got_q.size() < 2500; k++) cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (acc_cnt !== 10000 || got_q.size() !== 2500)
            $display("FAIL stream_count: accepted=%0d words=%0d want 10000/2500",
                     acc_cnt, got_q.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        n_total++;
        if (bad != 0 || exp_q.size() !== got_q.size())
            $display("FAIL stream_data: mismatched=%0d model=%0d got=%0d want 0 and equal sizes",
                     bad, exp_q.size(), got_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, 4'(i + 1), 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b0, 4'h0, 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
        n_total++;
        if (s_enb !== 1'b1) $display("FAIL mid_inflight: enb=%b want 1", s_enb);
        else n_pass++;
        reset = 1'b1;
        cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (s_wv !== 1'b0 || s_ready !== 1'b0 || s_enb !== 1'b0)
            $display("FAIL mid_reset_cycle: valid=%b ready=%b enb=%b want 0/0/0", s_wv, s_ready, s_enb);
        else n_pass++;
        reset = 1'b0;
        got_q.delete();
        cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (s_wv !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL mid_after: valid=%b ready=%b want 0/1", s_wv, s_ready);
        else n_pass++;
        cycle(1'b1, 4'h5, 1'b1);
        cycle(1'b1, 4'h6, 1'b1);
        cycle(1'b1, 4'h7, 1'b1);
        cycle(1'b1, 4'h8, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (got_q.size() !== 1 || got_q[0] !== 16'h8765)
            $display("FAIL mid_first_word: count=%0d first=%h want 1/8765", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'(9 - i), 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, 4'h0, 1'b0);
        flush = 1'b1;
        cycle(1'b1, 4'hF, 1'b1);
        n_total++;
        if (s_ready !== 1'b0 || s_wv !== 1'b0 || s_ena !== 1'b0)
            $display("FAIL flush_cycle: ready=%b valid=%b ena=%b want 0/0/0", s_ready, s_wv, s_ena);
        else n_pass++;
        flush = 1'b0;
        got_q.delete();
        cycle(1'b1, 4'hB, 1'b1);
        cycle(1'b1, 4'hC, 1'b1);
        cycle(1'b1, 4'hD, 1'b1);
        cycle(1'b1, 4'hE, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b0, 4'h0, 1'b1);
        n_total++;
        if (got_q.size() !== 1 || got_q[0] !== 16'hEDCB)
            $display("FAIL flush_first_word: count=%0d first=%h want 1/EDCB", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
        else n_pass++;
    endtask

`ifdef RAMB_FIFO_LEVEL_EN
    task automatic test_level();
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 1'b0);
        n_total++;
        if (fill_words !== 12'd4 || almost_full !== 1'b1)
            $display("FAIL level_four: fill=%0d afull=%b want 4/1", fill_words, almost_full);
        else n_pass++;
        cycle(1'b0, 4'h0, 1'b1);
        for (int k = 0; k < 6; k++) cycle(1'b0, 4'h0, 1'b0);
        n_total++;
        if (fill_words !== 12'd3 || almost_full !== 1'b0)
            $display("FAIL level_three: fill=%0d afull=%b want 3/0", fill_words, almost_full);
        else n_pass++;
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_pass         = 0;
        n_total        = 0;
        acc_cnt        = 0;
        m_word         = '0;
        m_cnt          = 0;
        reset          = 1'b1;
        flush          = 1'b0;
        bus.nib_valid  = 1'b0;
        bus.nib_data   = 4'h0;
        bus.word_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_partial();
        test_full();
        test_stream();
        test_reset_mid();
        test_flush();
`ifdef RAMB_FIFO_LEVEL_EN
        test_level();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
